// File: rtl/lcd1602_pkg.sv
// Shared types and HD44780 command constants for the LCD1602 character driver.
package lcd1602_pkg;

    typedef enum logic [2:0] {
        StPwrWait,
        StInit,
        StSetL1,
        StWrL1,
        StSetL2,
        StWrL2
    } lcd_state_e;

    // Each byte write is split into three tick-long phases.
    typedef enum logic [1:0] {
        PhSetup,
        PhEnHi,
        PhEnLo
    } lcd_phase_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;
    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider producing a one-clk tick every TICK_DIV clocks.
module lcd_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CntW = $clog2(TICK_DIV);

    logic [CntW-1:0] cnt_q;

    // First tick lands exactly TICK_DIV clocks after reset release.
    assign tick = (cnt_q == CntW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/lcd1602_driver.sv
// HD44780 8-bit write-only driver: power wait, init, then refreshes a 2x16 frame forever.
module lcd1602_driver
    import lcd1602_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned POWER_TICKS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] dis_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);

    localparam int unsigned WaitW = (POWER_TICKS > 1) ? $clog2(POWER_TICKS) : 1;

    logic tick;

    lcd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    lcd_state_e   state_q, state_d;
    lcd_phase_e   phase_q, phase_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [3:0]   idx_q, idx_d;
    logic [255:0] shadow_q, shadow_d;
    logic         rs_q, rs_d;
    logic         en_q, en_d;
    logic [7:0]   data_q, data_d;
    logic         init_done_q, init_done_d;
    logic         frame_done_q, frame_done_d;
    logic [7:0]   byte_sel;

    // Byte to present in the setup phase of the current write.
    always_comb begin
        byte_sel = 8'h00;
        case (state_q)
            StInit:  byte_sel = init_cmd(idx_q[1:0]);
            StSetL1: byte_sel = CMD_LINE1;
            StWrL1:  byte_sel = shadow_q[{1'b0, idx_q, 3'b000} +: 8];
            StSetL2: byte_sel = CMD_LINE2;
            StWrL2:  byte_sel = shadow_q[{1'b1, idx_q, 3'b000} +: 8];
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        wait_d       = wait_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        rs_d         = rs_q;
        en_d         = en_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;

        if (tick) begin
            if (state_q == StPwrWait) begin
                if (wait_q == WaitW'(POWER_TICKS - 1)) begin
                    wait_d  = '0;
                    state_d = StInit;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end else begin
                case (phase_q)
                    PhSetup: begin
                        en_d    = 1'b0;
                        rs_d    = (state_q == StWrL1) || (state_q == StWrL2);
                        data_d  = byte_sel;
                        phase_d = PhEnHi;
                        // Snapshot the frame so a mid-frame update never tears the display.
                        if (state_q == StSetL1) begin
                            shadow_d = dis_data;
                        end
                    end
                    PhEnHi: begin
                        en_d    = 1'b1;
                        phase_d = PhEnLo;
                    end
                    PhEnLo: begin
                        en_d    = 1'b0;
                        phase_d = PhSetup;
                        case (state_q)
                            StInit: begin
                                if (idx_q == 4'd3) begin
                                    idx_d       = 4'd0;
                                    init_done_d = 1'b1;
                                    state_d     = StSetL1;
                                end else begin
                                    idx_d = idx_q + 4'd1;
                                end
                            end
                            StSetL1: state_d = StWrL1;
                            StWrL1: begin
                                idx_d = idx_q + 4'd1;
                                if (idx_q == 4'd15) begin
                                    state_d = StSetL2;
                                end
                            end
                            StSetL2: state_d = StWrL2;
                            StWrL2: begin
                                idx_d = idx_q + 4'd1;
                                if (idx_q == 4'd15) begin
                                    state_d      = StSetL1;
                                    frame_done_d = 1'b1;
                                end
                            end
                            default: state_d = StPwrWait;
                        endcase
                    end
                    default: phase_d = PhSetup;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StPwrWait;
            phase_q      <= PhSetup;
            wait_q       <= '0;
            idx_q        <= 4'd0;
            shadow_q     <= {32{CHAR_SPACE}};
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            data_q       <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            wait_q       <= wait_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            rs_q         <= rs_d;
            en_q         <= en_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = en_q;
    assign lcd_data   = data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd1602_driver.sv
// Scoreboard bench for lcd1602_driver: expected bus writes queued by the driver, popped per enable pulse.
module tb_lcd1602_driver;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [255:0] dis_data;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         frame_done;

    lcd1602_driver #(
        .TICK_DIV    (4),
        .POWER_TICKS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dis_data   (dis_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pops    = 0;
    int   fd_count = 0;
    int   rel_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [255:0] mk_frame(input string l1, input string l2);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            f[8*k +: 8]      = l1[k];
            f[8*(k+16) +: 8] = l2[k];
        end
        return f;
    endfunction

    task automatic push_init();
        exp_q.push_back(exp_t'{1'b0, 8'h38, 1'b0});
        exp_q.push_back(exp_t'{1'b0, 8'h0C, 1'b0});
        exp_q.push_back(exp_t'{1'b0, 8'h06, 1'b0});
        exp_q.push_back(exp_t'{1'b0, 8'h01, 1'b0});
    endtask

    task automatic push_frame(input logic [255:0] f);
        exp_q.push_back(exp_t'{1'b0, 8'h80, 1'b0});
        for (int k = 0; k < 16; k++) exp_q.push_back(exp_t'{1'b1, f[8*k +: 8], 1'b0});
        exp_q.push_back(exp_t'{1'b0, 8'hC0, 1'b0});
        for (int k = 16; k < 32; k++) exp_q.push_back(exp_t'{1'b1, f[8*k +: 8], k == 31});
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (pops < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check_eq(tag, (pops >= n), 1);
    endtask

    // Bus monitor: en pulse width, rs/data stability, ordering against the scoreboard.
    initial begin
        logic       en_prev, rs_prev, init_prev, fd_prev, first_rise, fd_seen;
        logic [7:0] data_prev;
        int         hi_cnt, bytes_rst, init_rise_cyc, last_fd_cyc;
        exp_t       it;
        en_prev = 0; rs_prev = 0; init_prev = 0; fd_prev = 0; first_rise = 0; fd_seen = 0;
        data_prev = 0; hi_cnt = 0; bytes_rst = 0; init_rise_cyc = 0; last_fd_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev = 0; init_prev = 0; fd_prev = 0; first_rise = 0; fd_seen = 0;
                hi_cnt = 0; bytes_rst = 0;
            end else begin
                if (init_done && !init_prev) init_rise_cyc = cyc;
                if (lcd_en) begin
                    if (en_prev) begin
                        check_eq("rs_stable", lcd_rs, rs_prev);
                        check_eq("data_stable", lcd_data, data_prev);
                    end else if (!first_rise) begin
                        first_rise = 1;
                        check_eq("first_en_delay", cyc - rel_cyc, 16);
                    end
                    hi_cnt++;
                end
                if (en_prev && !lcd_en) begin
                    check_eq("en_width", hi_cnt, 4);
                    check_eq("rw_low", lcd_rw, 0);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_write", 1, 0);
                    end else begin
                        it = exp_q.pop_front();
                        check_eq("rs", lcd_rs, it.rs);
                        check_eq("data", lcd_data, it.data);
                        check_eq("frame_done_at_write", frame_done, it.last);
                    end
                    check_eq("init_done", init_done, (bytes_rst >= 3));
                    bytes_rst++;
                    pops++;
                    hi_cnt = 0;
                end else if (frame_done) begin
                    check_eq("frame_done_stray", 1, 0);
                end
                if (frame_done) begin
                    if (fd_prev) check_eq("frame_done_width", 2, 1);
                    else begin
                        fd_count++;
                        if (!fd_seen) check_eq("frame_period_first", cyc - init_rise_cyc, 408);
                        else check_eq("frame_period", cyc - last_fd_cyc, 408);
                        fd_seen = 1;
                        last_fd_cyc = cyc;
                    end
                end
                en_prev = lcd_en; rs_prev = lcd_rs; data_prev = lcd_data;
                init_prev = init_done; fd_prev = frame_done;
            end
        end
    end

    initial begin
        logic [255:0] f_old, f_new;
        int c;
        f_old = mk_frame(" smart pill box ", "    12:34:56    ");
        f_new = f_old;
        f_new[8*3 +: 8] = 8'h07;  // non-printable passes through
        rst_n = 1'b0;
        dis_data = f_old;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rs", lcd_rs, 0);
        check_eq("rst_rw", lcd_rw, 0);
        check_eq("rst_en", lcd_en, 0);
        check_eq("rst_data", lcd_data, 8'h00);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_frame_done", frame_done, 0);

        push_init();
        push_frame(f_old);
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;

        // Change byte 3 while line 1 is at index 8; frame 1 must keep the old byte.
        wait_pops(13, 2000, "timeout_idx8");
        dis_data = f_new;
        push_frame(f_new);
        push_frame(f_new);
        wait_pops(106, 3000, "timeout_3frames");
        check_eq("fd_count_3", fd_count, 3);

        push_frame(f_new);
        wait_pops(127, 2000, "timeout_wrl2");
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!lcd_en && c < 40);
        check_eq("en_high_before_rst", lcd_en, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_en", lcd_en, 0);
        check_eq("rst_mid_init_done", init_done, 0);
        exp_q.delete();
        pops = 0;
        repeat (2) @(posedge clk);
        push_init();
        push_frame(f_new);
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_pops(38, 2000, "timeout_rerun");
        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("fd_count_total", fd_count, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
